// File: rtl/memory_access.sv
// MEM pipeline stage: issues loads/stores on the data bus, passes everything
// else straight through, and reports stage completion on ok.
package memory_access_pkg;
  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    word_t       inst_pc;
    word_t       alu_result;
    word_t       reg2_value;
    logic [4:0]  reg_dest_addr;
    logic        reg_write_enable;
  } ex_mem;

  typedef struct packed {
    logic [4:0]  reg_dest_addr;
    logic        reg_write_enable;
    word_t       result;
    logic [31:0] inst;
    word_t       inst_pc;
    logic        valid;
  } mem_wb;

  typedef struct packed {
    logic        valid;
    word_t       addr;
    msize_t      size;
    logic [7:0]  strobe;
    word_t       data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    word_t       data;
  } dbus_resp_t;
endpackage

module memory_access
  import memory_access_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ex_mem      ex_mem_state,
  output mem_wb      mem_wb_state,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic [4:0] forward_reg_dest_addr,
  output logic       forward_reg_write_enable,
  output word_t      forward_reg_write_data,
  output logic       ok
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t     state_q, state_d;
  word_t      load_buf_q, load_buf_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_mem;
  msize_t     size;
  logic [7:0] size_mask;
  logic [2:0] byte_off;
  logic [5:0] shamt;
  word_t      raw;
  word_t      load_ext;
  logic       req_valid;
  logic       capture;
  word_t      result;

  // The bus handshake only completes on data_ok; address acceptance is not tracked.
  logic       addr_ok_unused;
  assign addr_ok_unused = dresp.addr_ok;

  // Decode the instruction and build address/size/strobe/data and the extended load value.
  always_comb begin
    opcode   = ex_mem_state.inst[6:0];
    funct3   = ex_mem_state.inst[14:12];
    is_load  = (opcode == 7'b0000011);
    is_store = (opcode == 7'b0100011);
    is_mem   = ex_mem_state.valid & (is_load | is_store);
    byte_off = ex_mem_state.alu_result[2:0];
    shamt    = {byte_off, 3'b000};
    unique case (funct3[1:0])
      2'b00:   begin size = MSIZE1; size_mask = 8'h01; end
      2'b01:   begin size = MSIZE2; size_mask = 8'h03; end
      2'b10:   begin size = MSIZE4; size_mask = 8'h0F; end
      default: begin size = MSIZE8; size_mask = 8'hFF; end
    endcase
    // Misaligned accesses simply lose whatever is shifted past the top byte.
    raw = dresp.data >> shamt;
    unique case (funct3[1:0])
      2'b00:   load_ext = funct3[2] ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   load_ext = funct3[2] ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   load_ext = funct3[2] ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

  // Access FSM: issue in IDLE, hold in WAIT, present the final result for one cycle in DONE.
  always_comb begin
    state_d   = state_q;
    ok        = 1'b0;
    req_valid = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          req_valid = 1'b1;
          if (dresp.data_ok) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          ok = 1'b1;
        end
      end
      S_WAIT: begin
        req_valid = 1'b1;
        if (dresp.data_ok) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ok      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset kills any in-flight access, including a data_ok that lands during it.
    if (reset) begin
      ok        = 1'b0;
      req_valid = 1'b0;
      capture   = 1'b0;
      state_d   = S_IDLE;
    end
    load_buf_d = capture ? load_ext : load_buf_q;
  end

  // State and load buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_buf_q <= 64'h0;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
    end
  end

  // Drive bus request, WB bundle and forwarding path.
  always_comb begin
    result = (state_q == S_DONE && is_load) ? load_buf_q : ex_mem_state.alu_result;

    dreq.valid  = req_valid;
    dreq.addr   = ex_mem_state.alu_result;
    dreq.size   = size;
    dreq.strobe = is_store ? (size_mask << byte_off) : 8'h00;
    dreq.data   = is_store ? (ex_mem_state.reg2_value << shamt) : 64'h0;

    mem_wb_state.reg_dest_addr    = ex_mem_state.reg_dest_addr;
    mem_wb_state.reg_write_enable = ex_mem_state.reg_write_enable;
    mem_wb_state.result           = result;
    mem_wb_state.inst             = ex_mem_state.inst;
    mem_wb_state.inst_pc          = ex_mem_state.inst_pc;
    mem_wb_state.valid            = ex_mem_state.valid & ok;

    forward_reg_dest_addr    = ex_mem_state.reg_dest_addr;
    forward_reg_write_enable = ex_mem_state.reg_write_enable & ex_mem_state.valid & ok;
    forward_reg_write_data   = result;
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: pass-through, loads, stores, misalignment and reset abort.
module tb_memory_access;
  import memory_access_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ex_mem      ex_mem_state;
  mem_wb      mem_wb_state;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic [4:0] fwd_addr;
  logic       fwd_we;
  word_t      fwd_data;
  logic       ok;

  int checks   = 0;
  int failures = 0;

  memory_access dut (
    .clk                      (clk),
    .reset                    (reset),
    .ex_mem_state             (ex_mem_state),
    .mem_wb_state             (mem_wb_state),
    .dreq                     (dreq),
    .dresp                    (dresp),
    .forward_reg_dest_addr    (fwd_addr),
    .forward_reg_write_enable (fwd_we),
    .forward_reg_write_data   (fwd_data),
    .ok                       (ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [31:0] inst, input word_t alu,
                        input word_t reg2, input logic [4:0] rd, input logic we);
    ex_mem_state.valid            = v;
    ex_mem_state.inst             = inst;
    ex_mem_state.inst_pc          = 64'h8000_0000 + {32'h0, inst};
    ex_mem_state.alu_result       = alu;
    ex_mem_state.reg2_value       = reg2;
    ex_mem_state.reg_dest_addr    = rd;
    ex_mem_state.reg_write_enable = we;
  endtask

  task automatic set_resp(input logic dok, input word_t data);
    dresp.addr_ok = 1'b0;
    dresp.data_ok = dok;
    dresp.data    = data;
  endtask

  // Advance to the next falling edge; inputs change and outputs are sampled there.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_ex(1'b1, 32'h0000_0003, 64'h1000, 64'h0, 5'd1, 1'b1);
    set_resp(1'b0, 64'h0);
    repeat (2) step();
    #1;
    chk("reset_dreq_valid", {63'h0, dreq.valid}, 64'h0);
    chk("reset_ok",         {63'h0, ok},         64'h0);

    // add: zero-cycle pass-through
    step();
    reset = 1'b0;
    set_ex(1'b1, 32'h0000_0033, 64'h5, 64'h0, 5'd3, 1'b1);
    dresp.data_ok = 1'b1;  // stray data_ok in IDLE without a request
    #1;
    chk("add_ok",         {63'h0, ok},                 64'h1);
    chk("add_dreq_valid", {63'h0, dreq.valid},         64'h0);
    chk("add_result",     mem_wb_state.result,         64'h5);
    chk("add_wb_valid",   {63'h0, mem_wb_state.valid}, 64'h1);
    chk("add_fwd_we",     {63'h0, fwd_we},             64'h1);
    chk("add_fwd_data",   fwd_data,                    64'h5);
    chk("add_fwd_addr",   {59'h0, fwd_addr},           64'd3);

    // lb at ...1003 with two wait cycles
    step();
    set_ex(1'b1, 32'h0000_0003, 64'h0000_0000_8000_1003, 64'h0, 5'd5, 1'b1);
    set_resp(1'b0, 64'h0);
    #1;
    chk("lb_ok0",     {63'h0, ok},         64'h0);
    chk("lb_valid0",  {63'h0, dreq.valid}, 64'h1);
    chk("lb_addr",    dreq.addr,           64'h0000_0000_8000_1003);
    chk("lb_size",    {62'h0, dreq.size},  {62'h0, MSIZE1});
    chk("lb_strobe",  {56'h0, dreq.strobe}, 64'h0);
    chk("lb_fwd_we0", {63'h0, fwd_we},     64'h0);
    step();
    dresp.addr_ok = 1'b1;  // address acceptance alone must not finish the access
    #1;
    chk("lb_ok1",    {63'h0, ok},         64'h0);
    chk("lb_valid1", {63'h0, dreq.valid}, 64'h1);
    step();
    set_resp(1'b1, 64'h0000_0000_8000_0000);
    #1;
    chk("lb_ok2",    {63'h0, ok},         64'h0);
    chk("lb_valid2", {63'h0, dreq.valid}, 64'h1);
    step();
    set_resp(1'b0, 64'h0);
    #1;
    chk("lb_done_ok",     {63'h0, ok},         64'h1);
    chk("lb_done_result", mem_wb_state.result, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_done_dreq",   {63'h0, dreq.valid}, 64'h0);
    chk("lb_done_fwd_we", {63'h0, fwd_we},     64'h1);
    step();
    #1;
    chk("lb_ok_one_cycle", {63'h0, ok}, 64'h0);

    // lhu at ...2006, data_ok in the issue cycle (still IDLE, so swap instruction now)
    set_ex(1'b1, 32'h0000_5003, 64'h0000_0000_0000_2006, 64'h0, 5'd6, 1'b1);
    set_resp(1'b1, 64'hBEEF_0000_0000_0000);
    #1;
    chk("lhu_ok0",   {63'h0, ok},        64'h0);
    chk("lhu_size",  {62'h0, dreq.size}, {62'h0, MSIZE2});
    step();
    set_resp(1'b0, 64'h0);
    #1;
    chk("lhu_ok",     {63'h0, ok},         64'h1);
    chk("lhu_result", mem_wb_state.result, 64'h0000_0000_0000_BEEF);

    // sw at ...3004
    step();
    set_ex(1'b1, 32'h0000_2023, 64'h0000_0000_0000_3004, 64'h1234_5678, 5'd0, 1'b0);
    #1;
    chk("sw_strobe", {56'h0, dreq.strobe}, 64'hF0);
    chk("sw_data",   dreq.data,            64'h1234_5678_0000_0000);
    chk("sw_size",   {62'h0, dreq.size},   {62'h0, MSIZE4});
    chk("sw_ok0",    {63'h0, ok},          64'h0);
    step();
    #1;
    chk("sw_hold_valid",  {63'h0, dreq.valid},  64'h1);
    chk("sw_hold_strobe", {56'h0, dreq.strobe}, 64'hF0);
    chk("sw_hold_data",   dreq.data,            64'h1234_5678_0000_0000);
    chk("sw_hold_addr",   dreq.addr,            64'h3004);
    dresp.data_ok = 1'b1;
    step();
    set_resp(1'b0, 64'h0);
    #1;
    chk("sw_ok",     {63'h0, ok},         64'h1);
    chk("sw_result", mem_wb_state.result, 64'h3004);
    chk("sw_fwd_we", {63'h0, fwd_we},     64'h0);
    chk("sw_dreq",   {63'h0, dreq.valid}, 64'h0);

    // misaligned sh at ...5007: upper byte of the halfword is dropped
    step();
    set_ex(1'b1, 32'h0000_1023, 64'h0000_0000_0000_5007, 64'hAABB, 5'd0, 1'b0);
    set_resp(1'b1, 64'h0);
    #1;
    chk("sh_mis_strobe", {56'h0, dreq.strobe}, 64'h80);
    chk("sh_mis_data",   dreq.data,            64'hBB00_0000_0000_0000);
    step();
    set_resp(1'b0, 64'h0);
    #1;
    chk("sh_mis_ok", {63'h0, ok}, 64'h1);

    // ld enters WAIT, then reset with a late data_ok
    step();
    set_ex(1'b1, 32'h0000_3003, 64'h0000_0000_0000_4000, 64'h0, 5'd7, 1'b1);
    step();
    reset = 1'b1;
    set_resp(1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    #1;
    chk("rst_wait_dreq", {63'h0, dreq.valid}, 64'h0);
    chk("rst_wait_ok",   {63'h0, ok},         64'h0);
    step();
    reset = 1'b0;
    set_resp(1'b0, 64'h0);
    #1;
    chk("rst_idle_reissue", {63'h0, dreq.valid}, 64'h1);
    chk("rst_idle_ok",      {63'h0, ok},         64'h0);
    set_ex(1'b1, 32'h0000_0033, 64'h77, 64'h0, 5'd8, 1'b1);
    #1;
    chk("rst_no_stale", mem_wb_state.result, 64'h77);
    chk("rst_add_ok",   {63'h0, ok},         64'h1);

    // valid=0 with sd encoding
    step();
    set_ex(1'b0, 32'h0000_3023, 64'h6000, 64'h1, 5'd0, 1'b0);
    #1;
    chk("inv_ok",       {63'h0, ok},                 64'h1);
    chk("inv_dreq",     {63'h0, dreq.valid},         64'h0);
    chk("inv_wb_valid", {63'h0, mem_wb_state.valid}, 64'h0);
    step();
    #1;
    chk("inv_still_ok", {63'h0, ok}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
